// File: rtl/julia_engine.sv
// julia_engine: one Julia-set pixel engine. It walks an interleaved subset of the
// frame (pixel indices ENGINE_ID, ENGINE_ID+NUM_ENGINES, ...). For each pixel it
// iterates z <- z^2 + c in Q4.12 and presents the escape count with its
// frame-buffer address until the memory controller frees it.
// Optional feature: define JULIA_STATS_EN to add the iter_total statistics output.
module julia_engine #(
  parameter int          ENGINE_ID   = 0,
  parameter int          NUM_ENGINES = 8,
  parameter int          WIDTH       = 640,
  parameter int          HEIGHT      = 480,
  parameter int          STEP        = 26,
  parameter int          MAX_ITER    = 255,
  parameter logic [31:0] FB_BASE     = 32'h0
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic signed [15:0] c_re,
  input  logic signed [15:0] c_im,
  input  logic               free,
  output logic [31:0]        address,
  output logic [7:0]         pixel,
  output logic               done,
  output logic               busy,
  output logic               frame_done
`ifdef JULIA_STATS_EN
  ,
  output logic [31:0]        iter_total
`endif
);

  // Frame geometry and counter widths. Every counter is sized so that the
  // post-increment value (before wrap or end-of-frame test) never overflows.
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(TOTAL + NUM_ENGINES + 1);
  localparam int X_W   = $clog2(2 * WIDTH + 1);
  localparam int Y_W   = $clog2(HEIGHT + 2);

  // First pixel of this engine, resolved at elaboration time.
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'(ENGINE_ID);
  localparam logic [X_W-1:0]   X_START   = X_W'(ENGINE_ID % WIDTH);
  localparam logic [Y_W-1:0]   Y_START   = Y_W'(ENGINE_ID / WIDTH);
  localparam bit               START_OOR = (ENGINE_ID >= TOTAL);

  localparam logic [IDX_W-1:0] IDX_TOTAL = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0] IDX_INC   = IDX_W'(NUM_ENGINES);
  localparam logic [X_W-1:0]   X_INC     = X_W'(NUM_ENGINES);
  localparam logic [X_W-1:0]   X_WRAP    = X_W'(WIDTH);
  localparam logic [7:0]       MAX_CNT   = 8'(MAX_ITER);

  // Escape threshold: |z|^2 = 4.0 in Q8.24.
  localparam logic [31:0] MAG_LIMIT = 32'h0400_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ITER = 3'd2,
    HOLD = 3'd3,
    NEXT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic signed [15:0] zr_q, zr_d;
  logic signed [15:0] zi_q, zi_d;
  logic signed [15:0] cre_q, cre_d;
  logic signed [15:0] cim_q, cim_d;
  logic [7:0]         count_q, count_d;
  logic [7:0]         pixel_q, pixel_d;
  logic               fd_idle_q, fd_idle_d;
  logic               iter_step;

  // Iteration datapath (Q8.24 products of Q4.12 operands).
  logic signed [31:0] zr_sq, zi_sq, zr_zi, sq_diff;
  logic [31:0]        mag;
  logic               escape;
  logic signed [15:0] zr_next, zi_next;

  // Both squares are non-negative and at most 2^30 each, so the sum is
  // computed unsigned and cannot wrap.
  assign zr_sq   = 32'(zr_q) * 32'(zr_q);
  assign zi_sq   = 32'(zi_q) * 32'(zi_q);
  assign zr_zi   = 32'(zr_q) * 32'(zi_q);
  assign sq_diff = zr_sq - zi_sq;
  assign mag     = $unsigned(zr_sq) + $unsigned(zi_sq);
  assign escape  = (mag > MAG_LIMIT) || (count_q == MAX_CNT);

  // Bits [27:12] of the Q8.24 result back to Q4.12; the doubled cross
  // product is taken as bits [26:11] of zr*zi to avoid a 33-bit product.
  assign zr_next = 16'(sq_diff >>> 12) + cre_q;
  assign zi_next = 16'(zr_zi >>> 11) + cim_q;

  // Starting point of the current pixel in the complex plane.
  logic signed [31:0] x_off, y_off, zr_init_full, zi_init_full;
  assign x_off        = $signed({{(32-X_W){1'b0}}, x_q}) - 32'(WIDTH / 2);
  assign y_off        = $signed({{(32-Y_W){1'b0}}, y_q}) - 32'(HEIGHT / 2);
  assign zr_init_full = x_off * 32'(STEP);
  assign zi_init_full = y_off * 32'(STEP);

  // Raster advance for the NEXT state.
  logic [IDX_W-1:0] idx_sum;
  logic [X_W-1:0]   x_sum;
  logic             last_pixel;
  assign idx_sum    = idx_q + IDX_INC;
  assign x_sum      = x_q + X_INC;
  assign last_pixel = (idx_sum >= IDX_TOTAL);

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    cre_d      = cre_q;
    cim_d      = cim_q;
    count_d    = count_q;
    pixel_d    = pixel_q;
    fd_idle_d  = 1'b0;
    iter_step  = 1'b0;
    frame_done = fd_idle_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (START_OOR) begin
            // No pixel belongs to this engine: finish the frame at once.
            fd_idle_d = 1'b1;
          end else begin
            cre_d   = c_re;
            cim_d   = c_im;
            idx_d   = IDX_START;
            x_d     = X_START;
            y_d     = Y_START;
            state_d = INIT;
          end
        end
      end

      INIT: begin
        zr_d    = 16'(zr_init_full);
        zi_d    = 16'(zi_init_full);
        count_d = 8'd0;
        state_d = ITER;
      end

      ITER: begin
        if (escape) begin
          pixel_d = count_q;
          state_d = HOLD;
        end else begin
          zr_d      = zr_next;
          zi_d      = zi_next;
          count_d   = count_q + 8'd1;
          iter_step = 1'b1;
        end
      end

      HOLD: begin
        if (free) begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        idx_d = idx_sum;
        if (x_sum >= X_WRAP) begin
          x_d = x_sum - X_WRAP;
          y_d = y_q + Y_W'(1);
        end else begin
          x_d = x_sum;
        end
        if (last_pixel) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = INIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      zr_q      <= '0;
      zi_q      <= '0;
      cre_q     <= '0;
      cim_q     <= '0;
      count_q   <= '0;
      pixel_q   <= '0;
      fd_idle_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      zr_q      <= zr_d;
      zi_q      <= zi_d;
      cre_q     <= cre_d;
      cim_q     <= cim_d;
      count_q   <= count_d;
      pixel_q   <= pixel_d;
      fd_idle_q <= fd_idle_d;
    end
  end

  // Address is only driven while the pixel is on offer, so it reads 0 in
  // reset and between pixels rather than leaking FB_BASE.
  assign done    = (state_q == HOLD);
  assign busy    = (state_q != IDLE);
  assign address = done ? (FB_BASE + 32'(idx_q)) : 32'h0;
  assign pixel   = pixel_q;

`ifdef JULIA_STATS_EN
  logic [31:0] iter_total_q;

  // Counts non-escaping iterations of the frame; cleared by a start taken in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      iter_total_q <= 32'h0;
    end else if ((state_q == IDLE) && start) begin
      iter_total_q <= 32'h0;
    end else if (iter_step) begin
      iter_total_q <= iter_total_q + 32'h1;
    end
  end

  assign iter_total = iter_total_q;
`endif

endmodule

// File: tb/tb_julia_engine.sv
// tb_julia_engine: self-checking bench for julia_engine on a 4x2 frame with a
// single engine. Expected pixels come from a plain-arithmetic Julia model.
module tb_julia_engine;

  localparam int          W      = 4;
  localparam int          H      = 2;
  localparam int          NE     = 1;
  localparam int          STP    = 4096;
  localparam int          MAXIT  = 255;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          TOTAL  = W * H;
  localparam int          WAIT_LIMIT = 600;

  logic               clk;
  logic               n_rst;
  logic               start;
  logic signed [15:0] c_re;
  logic signed [15:0] c_im;
  logic               free;
  logic [31:0]        address;
  logic [7:0]         pixel;
  logic               done;
  logic               busy;
  logic               frame_done;
`ifdef JULIA_STATS_EN
  logic [31:0]        iter_total;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  julia_engine #(
    .ENGINE_ID  (0),
    .NUM_ENGINES(NE),
    .WIDTH      (W),
    .HEIGHT     (H),
    .STEP       (STP),
    .MAX_ITER   (MAXIT),
    .FB_BASE    (BASE)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .c_re      (c_re),
    .c_im      (c_im),
    .free      (free),
    .address   (address),
    .pixel     (pixel),
    .done      (done),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef JULIA_STATS_EN
    ,
    .iter_total(iter_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reduce to a signed 16-bit value (two's-complement wrap).
  function automatic int wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  // Escape count of pixel (x,y): z0 from the pixel grid, z <- z^2 + c in
  // Q4.12, escape when |z|^2 > 4 or the cap is reached.
  function automatic int model_pixel(input int x, input int y, input int cre, input int cim);
    int     zr, zi, nzr;
    longint zr2, zi2, zrzi;
    zr = wrap16(longint'((x - W / 2) * STP));
    zi = wrap16(longint'((y - H / 2) * STP));
    for (int n = 0; n <= MAXIT; n++) begin
      zr2  = longint'(zr) * longint'(zr);
      zi2  = longint'(zi) * longint'(zi);
      zrzi = longint'(zr) * longint'(zi);
      if ((zr2 + zi2) > 64'sh0400_0000 || n == MAXIT) return n;
      nzr = wrap16(((zr2 - zi2) >>> 12) + longint'(cre));
      zi  = wrap16(((2 * zrzi) >>> 12) + longint'(cim));
      zr  = nzr;
    end
    return MAXIT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full frame: start, collect every pixel, free it after a delay,
  // and check handshake, frame_done and busy around each release.
  task automatic run_frame(input string name, input int cre, input int cim,
                           input int max_delay, input bit noisy, input int stall0);
    int          exp_pix, n, dly, sum_it;
    logic [31:0] exp_addr;
    sum_it = 0;
    c_re   = 16'(cre);
    c_im   = 16'(cim);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      exp_pix  = model_pixel(i % W, i / W, cre, cim);
      exp_addr = BASE + 32'(i);
      sum_it  += exp_pix;
      n = 0;
      while (done !== 1'b1 && n < WAIT_LIMIT) begin
        if (noisy) begin
          start = 1'($urandom_range(0, 1));
          free  = 1'($urandom_range(0, 1));
          c_re  = 16'($urandom);
          c_im  = 16'($urandom);
        end
        tick();
        n++;
      end
      start = 1'b0;
      free  = 1'b0;
      check_cnt++;
      if (done !== 1'b1) begin
        $display("FAIL %s done_timeout pixel %0d: done=%b after %0d cycles, required 1", name, i, done, n);
        return;
      end
      pass_cnt++;
      $display("%s pixel %0d addr %h val %0d (expect %h %0d)", name, i, address, pixel, exp_addr, exp_pix);
      check_cnt++;
      if (address !== exp_addr) $display("FAIL %s address pixel %0d: got %h, required %h", name, i, address, exp_addr);
      else pass_cnt++;
      check_cnt++;
      if (pixel !== 8'(exp_pix)) $display("FAIL %s pixel_value pixel %0d: got %0d, required %0d", name, i, pixel, exp_pix);
      else pass_cnt++;
      check_cnt++;
      if (busy !== 1'b1 || frame_done !== 1'b0)
        $display("FAIL %s hold_flags pixel %0d: busy=%b frame_done=%b, required 1 0", name, i, busy, frame_done);
      else pass_cnt++;

      dly = (i == 0 && stall0 > 0) ? stall0 : int'($urandom_range(0, max_delay));
      for (int k = 0; k < dly; k++) begin
        tick();
        check_cnt++;
        if (done !== 1'b1 || address !== exp_addr || pixel !== 8'(exp_pix))
          $display("FAIL %s hold_stable pixel %0d cycle %0d: done=%b addr=%h pix=%0d, required 1 %h %0d",
                   name, i, k, done, address, pixel, exp_addr, exp_pix);
        else pass_cnt++;
      end

      free = 1'b1;
      tick();
      free = 1'b0;
      check_cnt++;
      if (done !== 1'b0 || busy !== 1'b1 || frame_done !== (i == TOTAL - 1))
        $display("FAIL %s release pixel %0d: done=%b busy=%b frame_done=%b, required 0 1 %b",
                 name, i, done, busy, frame_done, (i == TOTAL - 1));
      else pass_cnt++;
      tick();
      check_cnt++;
      if (frame_done !== 1'b0 || busy !== (i != TOTAL - 1))
        $display("FAIL %s after_release pixel %0d: frame_done=%b busy=%b, required 0 %b",
                 name, i, frame_done, busy, (i != TOTAL - 1));
      else pass_cnt++;
    end
`ifdef JULIA_STATS_EN
    check_cnt++;
    if (iter_total !== 32'(sum_it)) $display("FAIL %s iter_total: got %0d, required %0d", name, iter_total, sum_it);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b0;
    free  = 1'b0;
    c_re  = '0;
    c_im  = '0;
    repeat (3) tick();
    check_cnt++;
    if ({done, busy, frame_done} !== 3'b000 || address !== 32'h0 || pixel !== 8'h0)
      $display("FAIL reset_state: done=%b busy=%b fd=%b addr=%h pix=%0d, required all 0",
               done, busy, frame_done, address, pixel);
    else pass_cnt++;
    n_rst = 1'b1;
    repeat (2) tick();
    check_cnt++;
    if ({done, busy, frame_done} !== 3'b000 || address !== 32'h0)
      $display("FAIL reset_release_idle: done=%b busy=%b fd=%b addr=%h, required 0 0 0 0",
               done, busy, frame_done, address);
    else pass_cnt++;
`ifdef JULIA_STATS_EN
    check_cnt++;
    if (iter_total !== 32'h0) $display("FAIL reset_iter_total: got %0d, required 0", iter_total);
    else pass_cnt++;
`endif
  endtask

  task automatic test_zero_c();
    run_frame("zero_c", 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_hold_stall();
    run_frame("hold_stall", 0, 0, 3, 1'b0, 50);
  endtask

  task automatic test_random_c();
    int cre, cim;
    for (int f = 0; f < 5; f++) begin
      cre = int'($urandom_range(0, 11468)) - 5734;
      cim = int'($urandom_range(0, 11468)) - 5734;
      $display("random_c frame %0d c=(%0d,%0d)", f, cre, cim);
      run_frame("random_c", cre, cim, 4, 1'b0, 0);
    end
  endtask

  task automatic test_ignored_inputs();
    int cre, cim;
    run_frame("ignored_zero_c", 0, 0, 2, 1'b1, 0);
    cre = int'($urandom_range(0, 11468)) - 5734;
    cim = int'($urandom_range(0, 11468)) - 5734;
    run_frame("ignored_rand_c", cre, cim, 2, 1'b1, 0);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    c_re  = '0;
    c_im  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (done !== 1'b1 && n < WAIT_LIMIT) begin
        tick();
        n++;
      end
      check_cnt++;
      if (done !== 1'b1) begin
        $display("FAIL reset_mid done_timeout pixel %0d: done=%b, required 1", i, done);
        return;
      end
      pass_cnt++;
      free = 1'b1;
      tick();
      free = 1'b0;
    end
    // Now in NEXT of pixel 1; a few cycles later pixel 2 is iterating.
    repeat (5) tick();
    check_cnt++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL reset_mid in_iter: busy=%b done=%b, required 1 0", busy, done);
    else pass_cnt++;
    n_rst = 1'b0;
    #1;
    check_cnt++;
    if ({done, busy, frame_done} !== 3'b000 || address !== 32'h0 || pixel !== 8'h0)
      $display("FAIL reset_mid outputs: done=%b busy=%b fd=%b addr=%h pix=%0d, required all 0",
               done, busy, frame_done, address, pixel);
    else pass_cnt++;
    tick();
    n_rst = 1'b1;
    repeat (3) tick();
    check_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid no_replay: done=%b busy=%b, required 0 0", done, busy);
    else pass_cnt++;
    run_frame("after_reset", 0, 0, 1, 1'b0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_c();
    test_hold_stall();
    test_random_c();
    test_ignored_inputs();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
